// File: rtl/adc_pkg.sv
// Shared constants for the ADC conversion sequencer: state encoding and
// default timing parameters.
package adc_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_WAIT_EOC = 3'd2;
    localparam logic [2:0] ST_READ     = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;

    localparam int DEF_DW        = 10;
    localparam int DEF_START_CYC = 2;
    localparam int DEF_RD_CYC    = 3;
    localparam int DEF_TIMEOUT   = 1023;
    localparam int DEF_PERIOD    = 1000;

    // One state counter serves START, WAIT_EOC and READ, so it must cover the largest load.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_data_latch.sv
// Capture register for the ADC parallel bus; loads on cap_en and holds
// the sample for the downstream consumer.
module adc_data_latch #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_en,
    input  logic [DW-1:0] adc_data,
    output logic [DW-1:0] sample
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample <= '0;
        end else if (cap_en) begin
            sample <= adc_data;
        end
    end

endmodule

// File: rtl/adc_conv_sequencer.sv
// Sequences one external ADC conversion (start, wait EOC, read, capture) and
// hands the captured sample downstream with valid/ready.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | waiting for trig or periodic tick
//  START    | adc_start held high for START_CYC cycles
//  WAIT_EOC | waiting for synchronised EOC, aborts after TIMEOUT cycles
//  READ     | adc_rd held high for RD_CYC cycles, capture on the last one
//  HOLD     | sample_valid high until the consumer accepts
module adc_conv_sequencer
    import adc_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int START_CYC = DEF_START_CYC,
    parameter int RD_CYC    = DEF_RD_CYC,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int PERIOD    = DEF_PERIOD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_periodic,
    input  logic          trig,
    output logic          adc_start,
    input  logic          adc_eoc,
    output logic          adc_rd,
    input  logic [DW-1:0] adc_data,
    output logic          cap_en,
    output logic [DW-1:0] sample,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          busy,
    output logic          timeout_err,
    output logic          overrun
);

    localparam int CNT_MAX = max3(START_CYC, RD_CYC, TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(PERIOD + 1);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [CW-1:0] st_cnt;
    logic [CW-1:0] st_cnt_nx;
    logic [PW-1:0] per_cnt;
    logic          eoc_m;
    logic          eoc_s;
    logic          tick;
    logic          go;
    logic          timeout_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eoc_m <= 1'b0;
            eoc_s <= 1'b0;
        end else begin
            eoc_m <= adc_eoc;
            eoc_s <= eoc_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
        end else if (!en_periodic) begin
            per_cnt <= '0;
        end else if (per_cnt == PW'(PERIOD - 1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    assign tick = en_periodic && (per_cnt == PW'(PERIOD - 1));
    assign go   = trig | (en_periodic & tick);

    // State timers count down from (length-1); the terminal count at zero ends the state.
    always_comb begin
        state_nx   = state;
        st_cnt_nx  = st_cnt;
        timeout_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go && !sample_valid) begin
                    state_nx  = ST_START;
                    st_cnt_nx = CW'(START_CYC - 1);
                end
            end
            ST_START: begin
                if (st_cnt == '0) begin
                    state_nx  = ST_WAIT_EOC;
                    st_cnt_nx = CW'(TIMEOUT - 1);
                end else begin
                    st_cnt_nx = st_cnt - 1'b1;
                end
            end
            ST_WAIT_EOC: begin
                if (eoc_s) begin
                    state_nx  = ST_READ;
                    st_cnt_nx = CW'(RD_CYC - 1);
                end else if (st_cnt == '0) begin
                    state_nx   = ST_IDLE;
                    timeout_nx = 1'b1;
                end else begin
                    st_cnt_nx = st_cnt - 1'b1;
                end
            end
            ST_READ: begin
                if (st_cnt == '0) begin
                    state_nx = ST_HOLD;
                end else begin
                    st_cnt_nx = st_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (sample_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            st_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            st_cnt      <= st_cnt_nx;
            timeout_err <= timeout_nx;
        end
    end

    // A tick is lost whenever a conversion or an unconsumed sample is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (tick && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end
    end

    assign adc_start    = (state == ST_START);
    assign adc_rd       = (state == ST_READ);
    assign cap_en       = (state == ST_READ) && (st_cnt == '0);
    assign sample_valid = (state == ST_HOLD);
    assign busy         = (state != ST_IDLE);

    adc_data_latch #(
        .DW (DW)
    ) u_latch (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (cap_en),
        .adc_data (adc_data),
        .sample   (sample)
    );

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Self-checking bench for adc_conv_sequencer with a behavioural ADC model
// and a scoreboard of expected samples.
`timescale 1ns/1ps
module tb_adc_conv_sequencer;

    localparam int DW      = 10;
    localparam int PERIOD  = 50;
    localparam int EOC_DLY = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en_periodic = 1'b0;
    logic          trig = 1'b0;
    logic          adc_eoc = 1'b0;
    logic          sample_ready = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_start, adc_rd, cap_en, sample_valid, busy, timeout_err, overrun;
    logic [DW-1:0] sample;

    logic          eoc_enable = 1'b1;
    logic [DW-1:0] data_q[$];
    logic [DW-1:0] exp_q[$];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    adc_conv_sequencer #(
        .DW        (DW),
        .START_CYC (2),
        .RD_CYC    (3),
        .TIMEOUT   (1023),
        .PERIOD    (PERIOD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en_periodic  (en_periodic),
        .trig         (trig),
        .adc_start    (adc_start),
        .adc_eoc      (adc_eoc),
        .adc_rd       (adc_rd),
        .adc_data     (adc_data),
        .cap_en       (cap_en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .overrun      (overrun)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ADC model: presents the next queued word on each start, raises EOC EOC_DLY cycles later.
    task automatic adc_model();
        logic start_q = 1'b0;
        int   cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (adc_rd) adc_eoc = 1'b0;
            if (adc_start && !start_q) begin
                if (data_q.size() > 0) adc_data = data_q.pop_front();
                cnt = eoc_enable ? EOC_DLY : 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) adc_eoc = 1'b1;
            end
            start_q = adc_start;
        end
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (adc_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", adc_start); end
        total++; if (adc_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b want=0", adc_rd); end
        total++; if (sample !== '0) begin bad++; $display("FAIL reset_sample got=%h want=000", sample); end
        total++; if ({sample_valid, busy, cap_en, timeout_err, overrun} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {sample_valid, busy, cap_en, timeout_err, overrun});
        end
        reset = 1'b0;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b want=0", busy); end
    endtask

    task automatic test_single_shot();
        int n = 0, n_start = 0, n_rd = 0, n_cap = 0, n_extra = 0;
        logic [DW-1:0] exp;
        eoc_enable = 1'b1;
        sample_ready = 1'b0;
        data_q.push_back(10'h2A5);
        exp_q.push_back(10'h2A5);
        trig = 1'b1; step(); trig = 1'b0;
        while (!sample_valid && n < 200) begin
            if (adc_start) n_start++;
            if (adc_rd) n_rd++;
            if (cap_en) n_cap++;
            step(); n++;
        end
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", sample_valid); end
        total++; if (n_start != 2) begin bad++; $display("FAIL single_start_len got=%0d want=2", n_start); end
        total++; if (n_rd != 3) begin bad++; $display("FAIL single_rd_len got=%0d want=3", n_rd); end
        total++; if (n_cap != 1) begin bad++; $display("FAIL single_cap_cnt got=%0d want=1", n_cap); end
        exp = exp_q.pop_front();
        total++; if (sample !== exp) begin bad++; $display("FAIL single_sample got=%h want=%h", sample, exp); end
        // trig while holding an unconsumed sample must be ignored
        trig = 1'b1; step(); trig = 1'b0;
        repeat (4) begin
            if (adc_start) n_extra++;
            step();
        end
        total++; if (n_extra != 0) begin bad++; $display("FAIL single_trig_ignored got=%0d want=0", n_extra); end
        total++; if (sample_valid !== 1'b1 || sample !== exp) begin
            bad++; $display("FAIL single_hold got=%b/%h want=1/%h", sample_valid, sample, exp);
        end
        sample_ready = 1'b1; step(); sample_ready = 1'b0;
        total++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_release got=%b/%b want=0/0", sample_valid, busy);
        end
    endtask

    task automatic test_timeout();
        int n = 0, n_cap = 0;
        eoc_enable = 1'b0;
        data_q.push_back(10'h155);
        trig = 1'b1; step(); trig = 1'b0;
        while (adc_start && n < 10) begin step(); n++; end
        n = 0;
        while (!timeout_err && n < 1100) begin
            if (cap_en) n_cap++;
            step(); n++;
        end
        total++; if (n != 1023) begin bad++; $display("FAIL timeout_cycles got=%0d want=1023", n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b want=0", busy); end
        step();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_pulse got=%b want=0", timeout_err); end
        total++; if (n_cap != 0) begin bad++; $display("FAIL timeout_no_cap got=%0d want=0", n_cap); end
        total++; if (sample !== 10'h2A5 || sample_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_sample got=%h/%b want=2a5/0", sample, sample_valid);
        end
        eoc_enable = 1'b1;
    endtask

    task automatic test_periodic();
        int n = 0, got = 0, last = -1;
        logic prev = 1'b0;
        logic [DW-1:0] exp;
        sample_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            data_q.push_back(DW'(i));
            exp_q.push_back(DW'(i));
        end
        en_periodic = 1'b1;
        while (got < 3 && n < 400) begin
            step(); n++;
            if (adc_start && !prev) begin
                if (last >= 0) begin
                    total++; if (n - last != PERIOD) begin bad++; $display("FAIL periodic_gap got=%0d want=%0d", n - last, PERIOD); end
                end
                last = n;
            end
            prev = adc_start;
            if (sample_valid) begin
                exp = exp_q.pop_front();
                total++; if (sample !== exp) begin bad++; $display("FAIL periodic_sample got=%h want=%h", sample, exp); end
                got++;
            end
        end
        en_periodic = 1'b0;
        total++; if (got != 3) begin bad++; $display("FAIL periodic_count got=%0d want=3", got); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL periodic_overrun got=%b want=0", overrun); end
        repeat (3) step();
        sample_ready = 1'b0;
    endtask

    task automatic test_overrun();
        int n = 0, n_start = 0;
        logic [DW-1:0] exp;
        sample_ready = 1'b0;
        data_q.push_back(10'h0AA);
        exp_q.push_back(10'h0AA);
        en_periodic = 1'b1;
        while (!sample_valid && n < 200) begin step(); n++; end
        exp = exp_q.pop_front();
        total++; if (sample !== exp) begin bad++; $display("FAIL overrun_first got=%h want=%h", sample, exp); end
        n = 0;
        while (!overrun && n < 120) begin
            step(); n++;
            if (adc_start) n_start++;
        end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", overrun); end
        total++; if (n_start != 0) begin bad++; $display("FAIL overrun_no_start got=%0d want=0", n_start); end
        total++; if (sample !== exp || sample_valid !== 1'b1) begin
            bad++; $display("FAIL overrun_hold got=%h/%b want=%h/1", sample, sample_valid, exp);
        end
        en_periodic = 1'b0;
        sample_ready = 1'b1; step(); sample_ready = 1'b0;
        step();
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        logic [DW-1:0] exp;
        data_q.push_back(10'h3C3);
        trig = 1'b1; step(); trig = 1'b0;
        while (!adc_rd && n < 100) begin step(); n++; end
        total++; if (adc_rd !== 1'b1) begin bad++; $display("FAIL midrd_reach got=%b want=1", adc_rd); end
        reset = 1'b1;
        #1;
        total++; if ({adc_rd, adc_start, sample_valid, busy} !== 4'b0) begin
            bad++; $display("FAIL midrd_outputs got=%b want=0000", {adc_rd, adc_start, sample_valid, busy});
        end
        total++; if (sample !== '0 || overrun !== 1'b0) begin
            bad++; $display("FAIL midrd_sample got=%h/%b want=000/0", sample, overrun);
        end
        step();
        reset = 1'b0;
        step();
        sample_ready = 1'b0;
        data_q.push_back(10'h0F0);
        exp_q.push_back(10'h0F0);
        trig = 1'b1; step(); trig = 1'b0;
        n = 0;
        while (!sample_valid && n < 200) begin step(); n++; end
        exp = exp_q.pop_front();
        total++; if (sample_valid !== 1'b1 || sample !== exp) begin
            bad++; $display("FAIL midrd_recover got=%b/%h want=1/%h", sample_valid, sample, exp);
        end
        sample_ready = 1'b1; step(); sample_ready = 1'b0;
    endtask

    task automatic test_trig_tick_same_cycle();
        int n_start = 0, n_cap = 0, got = 0;
        logic prev = 1'b0;
        logic [DW-1:0] exp;
        sample_ready = 1'b1;
        data_q.push_back(10'h1E1);
        exp_q.push_back(10'h1E1);
        step();
        en_periodic = 1'b1;
        // counter reads PERIOD-1 after PERIOD-1 enabled edges; trig lines up with that tick
        repeat (PERIOD - 1) step();
        trig = 1'b1; step(); trig = 1'b0;
        en_periodic = 1'b0;
        repeat (80) begin
            if (adc_start && !prev) n_start++;
            prev = adc_start;
            if (cap_en) n_cap++;
            if (sample_valid) begin
                exp = exp_q.pop_front();
                total++; if (sample !== exp) begin bad++; $display("FAIL both_sample got=%h want=%h", sample, exp); end
                got++;
            end
            step();
        end
        total++; if (n_start != 1) begin bad++; $display("FAIL both_starts got=%0d want=1", n_start); end
        total++; if (n_cap != 1) begin bad++; $display("FAIL both_caps got=%0d want=1", n_cap); end
        total++; if (got != 1) begin bad++; $display("FAIL both_valids got=%0d want=1", got); end
        sample_ready = 1'b0;
    endtask

    initial begin
        fork
            adc_model();
        join_none
        reset = 1'b1;
        test_reset();
        test_single_shot();
        test_timeout();
        test_periodic();
        test_overrun();
        test_reset_mid_read();
        test_trig_tick_same_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
